ifac8_twiddle_rot_pipe: RTL and testbench

// Streaming inverse-direction twiddle rotator for the 8-point IFFT path.

---
 rtl/ifac8_twiddle_rot_pipe.sv | 105 ++++++++++
 tb/tb_ifac8_twiddle_rot_pipe.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifac8_twiddle_rot_pipe.sv
// Streaming conjugate-twiddle rotator for the 8-point IFFT path: dout = din * e^{+j*2*pi*k/8}.
// Two-stage valid/ready pipeline; k steps once per BLK accepted beats and resyncs on in_sof.
module ifac8_twiddle_rot_pipe #(
  parameter int unsigned DIN_W  = 14,
  parameter int unsigned DOUT_W = 16,
  parameter int unsigned BLK    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic signed [DIN_W-1:0]  din_R,
  input  logic signed [DIN_W-1:0]  din_Q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic [2:0]               out_k,
  output logic signed [DOUT_W-1:0] dout_R,
  output logic signed [DOUT_W-1:0] dout_Q
);

  localparam int unsigned CW = 3 + $clog2(BLK);
  localparam int unsigned MW = DIN_W + 10;

  logic                 en;
  logic                 acc;
  logic [CW-1:0]        cnt;
  logic [2:0]           k_cur;
  logic signed [9:0]    c_r;
  logic signed [9:0]    c_q;
  logic signed [MW-1:0] m_r;
  logic signed [MW-1:0] m_q;
  logic signed [MW-1:0] rnd_r;
  logic signed [MW-1:0] rnd_q;

  logic                 s1_valid;
  logic                 s1_sof;
  logic [2:0]           s1_k;
  logic signed [MW-1:0] s1_m_r;
  logic signed [MW-1:0] s1_m_q;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;
  assign acc      = in_valid & en;
  // The sof beat itself always rotates by k=0, regardless of where the counter was.
  assign k_cur    = in_sof ? 3'd0 : cnt[CW-1 -: 3];

  always_comb begin
    c_r = '0;
    c_q = '0;
    unique case (k_cur)
      3'd0: begin c_r =  10'sd256; c_q =  10'sd0;   end
      3'd1: begin c_r =  10'sd181; c_q =  10'sd181; end
      3'd2: begin c_r =  10'sd0;   c_q =  10'sd256; end
      3'd3: begin c_r = -10'sd181; c_q =  10'sd181; end
      3'd4: begin c_r = -10'sd256; c_q =  10'sd0;   end
      3'd5: begin c_r = -10'sd181; c_q = -10'sd181; end
      3'd6: begin c_r =  10'sd0;   c_q = -10'sd256; end
      3'd7: begin c_r =  10'sd181; c_q = -10'sd181; end
      default: begin c_r = '0; c_q = '0; end
    endcase
  end

  always_comb begin
    m_r   = MW'(c_r) * MW'(din_R) - MW'(c_q) * MW'(din_Q);
    m_q   = MW'(c_r) * MW'(din_Q) + MW'(c_q) * MW'(din_R);
    // Round half up: add half an LSB of the Q8 result before the arithmetic shift.
    rnd_r = (s1_m_r + MW'(128)) >>> 8;
    rnd_q = (s1_m_q + MW'(128)) >>> 8;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_k      <= '0;
      s1_m_r    <= '0;
      s1_m_q    <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_k     <= '0;
      dout_R    <= '0;
      dout_Q    <= '0;
    end else begin
      if (acc) begin
        cnt <= in_sof ? CW'(1) : cnt + CW'(1);
      end
      if (en) begin
        s1_valid  <= in_valid;
        s1_sof    <= in_sof & in_valid;
        s1_k      <= k_cur;
        s1_m_r    <= m_r;
        s1_m_q    <= m_q;
        out_valid <= s1_valid;
        out_sof   <= s1_sof;
        out_k     <= s1_k;
        dout_R    <= DOUT_W'(rnd_r);
        dout_Q    <= DOUT_W'(rnd_q);
      end
    end
  end

endmodule

// File: tb/tb_ifac8_twiddle_rot_pipe.sv
// Bench for ifac8_twiddle_rot_pipe: a BLK=1 and a BLK=4 instance share one input stream and are
// compared against a trig-derived reference model with frame-index bookkeeping.
module tb_ifac8_twiddle_rot_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_sof, out_ready;
  logic signed [13:0] din_r, din_q;

  logic in_ready, out_valid, out_sof;
  logic [2:0] out_k;
  logic signed [15:0] dout_r, dout_q;
  logic in_ready4, out_valid4, out_sof4;
  logic [2:0] out_k4;
  logic signed [15:0] dout_r4, dout_q4;

  ifac8_twiddle_rot_pipe #(.DIN_W(14), .DOUT_W(16), .BLK(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .din_R(din_r), .din_Q(din_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_k(out_k), .dout_R(dout_r), .dout_Q(dout_q)
  );

  ifac8_twiddle_rot_pipe #(.DIN_W(14), .DOUT_W(16), .BLK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_sof(in_sof),
    .din_R(din_r), .din_Q(din_q), .out_valid(out_valid4), .out_ready(out_ready),
    .out_sof(out_sof4), .out_k(out_k4), .dout_R(dout_r4), .dout_Q(dout_q4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int sof;
    int r;
    int q;
    int cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    exp_k4[$];
  int    got_k4[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    cnt1 = 0;
  int    cnt4 = 0;

  // Q8 coefficient of e^{+j*2*pi*k/8}, rounded to nearest.
  function automatic int coef(input int k, input bit imag);
    real a, x;
    a = 2.0 * 3.14159265358979 * k / 8.0;
    x = imag ? $sin(a) : $cos(a);
    return $rtoi($floor(256.0 * x + 0.5));
  endfunction

  function automatic int rnd8(input int m);
    return $rtoi($floor(m / 256.0 + 0.5));
  endfunction

  function automatic int rnd14();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: predicts each accepted beat and records each delivered beat.
  always @(negedge clk) begin
    beat_t b;
    beat_t g;
    int kk;
    if (!rst_n) begin
      cnt1 = 0;
      cnt4 = 0;
    end else begin
      if (in_valid && in_ready) begin
        kk    = in_sof ? 0 : cnt1 % 8;
        b.k   = kk;
        b.sof = int'(in_sof);
        b.r   = rnd8(coef(kk, 0) * int'(din_r) - coef(kk, 1) * int'(din_q));
        b.q   = rnd8(coef(kk, 0) * int'(din_q) + coef(kk, 1) * int'(din_r));
        b.cyc = cyc;
        exp_q.push_back(b);
        cnt1 = in_sof ? 1 : (cnt1 + 1) % 8;
        exp_k4.push_back(in_sof ? 0 : (cnt4 / 4) % 8);
        cnt4 = in_sof ? 1 : (cnt4 + 1) % 32;
      end
      if (out_valid && out_ready) begin
        g.k = int'(out_k); g.sof = int'(out_sof); g.r = int'(dout_r); g.q = int'(dout_q);
        g.cyc = cyc;
        got_q.push_back(g);
      end
      if (out_valid4 && out_ready) got_k4.push_back(int'(out_k4));
    end
  end

  task automatic clear_q();
    exp_q.delete(); got_q.delete(); exp_k4.delete(); got_k4.delete();
  endtask

  task automatic send(input bit s, input int r, input int q);
    int n;
    in_valid = 1'b1; in_sof = s; din_r = 14'(r); din_q = 14'(q);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      n_checks++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((got_q.size() < exp_q.size() || got_k4.size() < exp_k4.size()) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); in_sof = 1'($urandom); din_r = 14'(rnd14()); din_q = 14'(rnd14());
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_sof, out_k, dout_r, dout_q, out_valid4, dout_r4} !== '0)
        $display("FAIL reset_state out_valid=%0b out_k=%0d dout=(%0d,%0d) required all 0",
                 out_valid, out_k, dout_r, dout_q);
      else n_pass++;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready in_ready=%0b required=1", in_ready);
    else n_pass++;
    clear_q();
    @(posedge clk); #1;
    send(1'b0, rnd14(), rnd14());
    drain();
    n_checks++;
    if (got_q.size() != 1 || exp_q.size() != 1)
      $display("FAIL reset_first_count got=%0d required=1", got_q.size());
    else if (got_q[0].k != 0 || got_q[0].r != exp_q[0].r || got_q[0].q != exp_q[0].q)
      $display("FAIL reset_first_beat k=%0d dout=(%0d,%0d) required k=0 (%0d,%0d)",
               got_q[0].k, got_q[0].r, got_q[0].q, exp_q[0].r, exp_q[0].q);
    else n_pass++;
  endtask

  task automatic test_sweep();
    int sw_r[8] = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    int sw_q[8] = '{0, 707, 1000, 707, 0, -707, -1000, -707};
    clear_q();
    for (int i = 0; i < 8; i++) send(i == 0, 1000, 0);
    drain();
    n_checks++;
    if (got_q.size() != 8 || exp_q.size() != 8)
      $display("FAIL sweep_count got=%0d required=8", got_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (got_q[i].r != sw_r[i] || got_q[i].q != sw_q[i] || got_q[i].k != i
            || got_q[i].sof != int'(i == 0) || got_q[i].cyc - exp_q[i].cyc != 2)
          $display("FAIL sweep_beat%0d dout=(%0d,%0d) k=%0d sof=%0d lat=%0d required (%0d,%0d) k=%0d sof=%0d lat=2",
                   i, got_q[i].r, got_q[i].q, got_q[i].k, got_q[i].sof,
                   got_q[i].cyc - exp_q[i].cyc, sw_r[i], sw_q[i], i, int'(i == 0));
        else n_pass++;
      end
    end
  endtask

  task automatic test_extremes();
    clear_q();
    send(1'b1, 0, 0);
    for (int i = 0; i < 3; i++) send(1'b0, rnd14(), rnd14());
    send(1'b0, -8192, 0);
    send(1'b0, -8192, -8192);
    drain();
    n_checks++;
    if (got_q.size() != 6) $display("FAIL extremes_count got=%0d required=6", got_q.size());
    else if (got_q[4].r != 8192 || got_q[4].q != 0 || got_q[4].k != 4)
      $display("FAIL extremes_k4 dout=(%0d,%0d) k=%0d required (8192,0) k=4",
               got_q[4].r, got_q[4].q, got_q[4].k);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 6) $display("FAIL extremes_k5_count got=%0d required=6", got_q.size());
    else if (got_q[5].r != 0 || got_q[5].q != 11584 || got_q[5].k != 5)
      $display("FAIL extremes_k5 dout=(%0d,%0d) k=%0d required (0,11584) k=5",
               got_q[5].r, got_q[5].q, got_q[5].k);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_q();
    fork
      begin
        send(1'b1, rnd14(), rnd14());
        for (int i = 1; i < 10; i++) send(1'b0, rnd14(), rnd14());
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          n_checks++;
          if (exp_q.size() <= got_q.size())
            $display("FAIL stall_hold_%0d no pending beat got=%0d", i, got_q.size());
          else if (in_ready !== 1'b0 || out_valid !== 1'b1
                   || int'(dout_r) != exp_q[got_q.size()].r
                   || int'(dout_q) != exp_q[got_q.size()].q
                   || int'(out_k) != exp_q[got_q.size()].k)
            $display("FAIL stall_hold_%0d in_ready=%0b out_valid=%0b dout=(%0d,%0d) k=%0d required 0 1 (%0d,%0d) k=%0d",
                     i, in_ready, out_valid, dout_r, dout_q, out_k, exp_q[got_q.size()].r,
                     exp_q[got_q.size()].q, exp_q[got_q.size()].k);
          else n_pass++;
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    n_checks++;
    if (got_q.size() != 10 || exp_q.size() != 10)
      $display("FAIL stall_count got=%0d required=10", got_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].r != exp_q[i].r || got_q[i].q != exp_q[i].q || got_q[i].k != i % 8)
        $display("FAIL stall_beat%0d dout=(%0d,%0d) k=%0d required (%0d,%0d) k=%0d",
                 i, got_q[i].r, got_q[i].q, got_q[i].k, exp_q[i].r, exp_q[i].q, i % 8);
      else n_pass++;
    end
  endtask

  task automatic test_blk();
    int lit[21];
    for (int i = 0; i < 13; i++) lit[i] = i / 4;
    for (int i = 13; i < 17; i++) lit[i] = 0;
    for (int i = 17; i < 21; i++) lit[i] = 1;
    clear_q();
    send(1'b1, rnd14(), rnd14());
    for (int i = 1; i < 13; i++) send(1'b0, rnd14(), rnd14());
    send(1'b1, rnd14(), rnd14());
    for (int i = 14; i < 21; i++) send(1'b0, rnd14(), rnd14());
    drain();
    n_checks++;
    if (got_k4.size() != 21) $display("FAIL blk4_count got=%0d required=21", got_k4.size());
    else n_pass++;
    for (int i = 0; i < got_k4.size() && i < 21; i++) begin
      n_checks++;
      if (got_k4[i] != lit[i]) $display("FAIL blk4_k%0d k=%0d required=%0d", i, got_k4[i], lit[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    clear_q();
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send($urandom_range(0, 7) == 0, rnd14(), rnd14());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    n_checks++;
    if (got_q.size() != 60 || exp_q.size() != 60 || got_k4.size() != 60)
      $display("FAIL random_count got=%0d got4=%0d required=60", got_q.size(), got_k4.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].r != exp_q[i].r || got_q[i].q != exp_q[i].q || got_q[i].k != exp_q[i].k
          || got_q[i].sof != exp_q[i].sof)
        $display("FAIL random_beat%0d dout=(%0d,%0d) k=%0d sof=%0d required (%0d,%0d) k=%0d sof=%0d",
                 i, got_q[i].r, got_q[i].q, got_q[i].k, got_q[i].sof,
                 exp_q[i].r, exp_q[i].q, exp_q[i].k, exp_q[i].sof);
      else n_pass++;
    end
    for (int i = 0; i < got_k4.size() && i < exp_k4.size(); i++) begin
      n_checks++;
      if (got_k4[i] != exp_k4[i])
        $display("FAIL random_blk4_k%0d k=%0d required=%0d", i, got_k4[i], exp_k4[i]);
      else n_pass++;
    end
  endtask

  task automatic test_midreset();
    clear_q();
    send(1'b1, rnd14(), rnd14());
    send(1'b0, rnd14(), rnd14());
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_valid4, out_k, dout_r, dout_q} !== '0)
      $display("FAIL midreset_flush out_valid=%0b out_valid4=%0b dout=(%0d,%0d) required 0",
               out_valid, out_valid4, dout_r, dout_q);
    else n_pass++;
    clear_q();
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b0, rnd14(), rnd14());
    drain();
    n_checks++;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_k4.size() != 1)
      $display("FAIL midreset_count got=%0d got4=%0d required=1", got_q.size(), got_k4.size());
    else if (got_q[0].k != 0 || got_k4[0] != 0 || got_q[0].r != exp_q[0].r
             || got_q[0].q != exp_q[0].q)
      $display("FAIL midreset_beat k=%0d k4=%0d dout=(%0d,%0d) required k=0 (%0d,%0d)",
               got_q[0].k, got_k4[0], got_q[0].r, got_q[0].q, exp_q[0].r, exp_q[0].q);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    din_r = '0; din_q = '0;
    test_reset();
    test_sweep();
    test_extremes();
    test_backpressure();
    test_blk();
    test_random();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
